// File: rtl/carregador_instrucao_if.sv
// Byte-stream handshake plus instruction-memory write port of the program loader.
// The slave modport is the loader's view; the master modport is the host/memory side.
interface carregador_instrucao_if;
   logic [7:0]  byte_in;
   logic        byte_valido;
   logic        byte_pronto;
   logic        mem_we;
   logic [8:0]  mem_endereco;
   logic [31:0] mem_dado;

   modport master (
      output byte_in,
      output byte_valido,
      input  byte_pronto,
      input  mem_we,
      input  mem_endereco,
      input  mem_dado
   );

   modport slave (
      input  byte_in,
      input  byte_valido,
      output byte_pronto,
      output mem_we,
      output mem_endereco,
      output mem_dado
   );
endinterface

// File: rtl/carregador_instrucao.sv
// Program loader: packs an MSB-first byte stream into 32-bit words, writes them to
// consecutive instruction-memory addresses and verifies a trailing XOR checksum.
module carregador_instrucao (
   input  logic                         ck,
   input  logic                         reset_n,
   input  logic                         inicio,
   input  logic [8:0]                   qtd,
   output logic                         ocupado,
   output logic                         concluido,
   output logic                         erro,
   carregador_instrucao_if.slave        barramento
);

   typedef enum logic [2:0] {OCIOSO, RECEBE, ESCREVE, CHECK, FIM} estado_t;

   estado_t     estado_reg, estado_next;
   logic [8:0]  qtd_reg, qtd_next;
   logic [8:0]  endereco_reg, endereco_next;
   logic [1:0]  cont_byte_reg, cont_byte_next;
   logic [7:0]  acc_reg, acc_next;
   logic [31:0] palavra_reg, palavra_next;
   logic [8:0]  mem_endereco_reg, mem_endereco_next;
   logic [31:0] mem_dado_reg, mem_dado_next;
   logic        erro_reg, erro_next;

   logic        byte_pronto;
   logic        transfere;
   logic [8:0]  endereco_inc;
   logic [31:0] palavra_desloc;

   always_ff @(posedge ck or negedge reset_n) begin
      if (!reset_n) begin
         estado_reg       <= OCIOSO;
         qtd_reg          <= '0;
         endereco_reg     <= '0;
         cont_byte_reg    <= '0;
         acc_reg          <= '0;
         palavra_reg      <= '0;
         mem_endereco_reg <= '0;
         mem_dado_reg     <= '0;
         erro_reg         <= 1'b0;
      end else begin
         estado_reg       <= estado_next;
         qtd_reg          <= qtd_next;
         endereco_reg     <= endereco_next;
         cont_byte_reg    <= cont_byte_next;
         acc_reg          <= acc_next;
         palavra_reg      <= palavra_next;
         mem_endereco_reg <= mem_endereco_next;
         mem_dado_reg     <= mem_dado_next;
         erro_reg         <= erro_next;
      end
   end

   assign byte_pronto    = (estado_reg == RECEBE) || (estado_reg == CHECK);
   assign transfere      = barramento.byte_valido && byte_pronto;
   assign endereco_inc   = endereco_reg + 9'd1;
   assign palavra_desloc = {palavra_reg[23:0], barramento.byte_in};

   always_comb begin
      estado_next       = estado_reg;
      qtd_next          = qtd_reg;
      endereco_next     = endereco_reg;
      cont_byte_next    = cont_byte_reg;
      acc_next          = acc_reg;
      palavra_next      = palavra_reg;
      mem_endereco_next = mem_endereco_reg;
      mem_dado_next     = mem_dado_reg;
      erro_next         = erro_reg;

      case (estado_reg)
         OCIOSO: begin
            if (inicio) begin
               qtd_next       = qtd;
               endereco_next  = '0;
               cont_byte_next = '0;
               acc_next       = '0;
               palavra_next   = '0;
               erro_next      = 1'b0;
               estado_next    = (qtd == 9'd0) ? CHECK : RECEBE;
            end
         end
         RECEBE: begin
            if (transfere) begin
               palavra_next   = palavra_desloc;
               acc_next       = acc_reg ^ barramento.byte_in;
               cont_byte_next = cont_byte_reg + 2'd1;
               // Output registers are loaded only here so they hold between writes.
               if (cont_byte_reg == 2'd3) begin
                  mem_dado_next     = palavra_desloc;
                  mem_endereco_next = endereco_reg;
                  estado_next       = ESCREVE;
               end
            end
         end
         ESCREVE: begin
            endereco_next = endereco_inc;
            estado_next   = (endereco_inc == qtd_reg) ? CHECK : RECEBE;
         end
         CHECK: begin
            if (transfere) begin
               erro_next   = (barramento.byte_in != acc_reg);
               estado_next = FIM;
            end
         end
         FIM: begin
            estado_next = OCIOSO;
         end
         default: begin
            estado_next = OCIOSO;
         end
      endcase
   end

   assign barramento.byte_pronto  = byte_pronto;
   assign barramento.mem_we       = (estado_reg == ESCREVE);
   assign barramento.mem_endereco = mem_endereco_reg;
   assign barramento.mem_dado     = mem_dado_reg;
   assign ocupado                 = (estado_reg != OCIOSO);
   assign concluido               = (estado_reg == FIM);
   assign erro                    = erro_reg;

endmodule

// File: tb/tb_carregador_instrucao.sv
// Directed bench for the program loader: streams byte sessions and checks writes,
// timing, checksum result, backpressure and mid-session reset.
module tb_carregador_instrucao;

   logic       ck;
   logic       reset_n;
   logic       inicio;
   logic [8:0] qtd;
   logic       ocupado;
   logic       concluido;
   logic       erro;

   carregador_instrucao_if bus ();

   carregador_instrucao dut (
      .ck         (ck),
      .reset_n    (reset_n),
      .inicio     (inicio),
      .qtd        (qtd),
      .ocupado    (ocupado),
      .concluido  (concluido),
      .erro       (erro),
      .barramento (bus.slave)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t0 = 0;

   // Monitor state, written only by the monitor processes.
   logic [8:0]  wr_addr[$];
   logic [31:0] wr_data[$];
   int          wr_cyc[$];
   int          conc_n = 0;
   int          conc_cyc = 0;
   logic        conc_erro = 1'b0;
   int          xfer_n = 0;

   always @(posedge ck) cyc <= cyc + 1;

   always @(negedge ck) begin
      if (reset_n) begin
         if (bus.mem_we) begin
            wr_addr.push_back(bus.mem_endereco);
            wr_data.push_back(bus.mem_dado);
            wr_cyc.push_back(cyc);
         end
         if (concluido) begin
            conc_n    = conc_n + 1;
            conc_cyc  = cyc;
            conc_erro = erro;
         end
         if (bus.byte_valido && bus.byte_pronto) xfer_n = xfer_n + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic start(input logic [8:0] q);
      inicio = 1'b1;
      qtd    = q;
      tick();
      t0     = cyc;
      inicio = 1'b0;
      qtd    = 9'($urandom);
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit done = 1'b0;
      bus.byte_in     = b;
      bus.byte_valido = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         if (bus.byte_pronto) done = 1'b1;
         tick();
      end
      chk("byte_accept_timeout", 64'(done), 64'd1);
   endtask

   task automatic idle(input int n);
      bus.byte_valido = 1'b0;
      repeat (n) tick();
   endtask

   task automatic wait_fim();
      bus.byte_valido = 1'b0;
      for (int i = 0; i < 30 && ocupado; i++) tick();
      chk("session_end_timeout", 64'(ocupado), 64'd0);
   endtask

   task automatic send_stream(input logic [7:0] ck_byte);
      send_byte(8'hB0); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h50); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
      send_byte(ck_byte);
   endtask

   int bw, bc, bx;

   initial begin
      reset_n         = 1'b0;
      inicio          = 1'b0;
      qtd             = '0;
      bus.byte_in     = '0;
      bus.byte_valido = 1'b0;

      // Reset held with random inputs.
      for (int i = 0; i < 3; i++) begin
         inicio          = 1'($urandom);
         qtd             = 9'($urandom);
         bus.byte_in     = 8'($urandom);
         bus.byte_valido = 1'($urandom);
         #7;
         chk("reset_outputs", {bus.byte_pronto, bus.mem_we, ocupado, concluido, erro,
                               bus.mem_endereco, bus.mem_dado}, 64'd0);
      end
      inicio          = 1'b0;
      bus.byte_valido = 1'b1;
      @(negedge ck);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_pronto", 64'(bus.byte_pronto), 64'd0);
      end
      chk("idle_no_write", 64'(wr_addr.size()), 64'd0);
      bus.byte_valido = 1'b0;

      // qtd=2, good checksum, continuous stream.
      bw = wr_addr.size(); bc = conc_n;
      start(9'd2);
      send_stream(8'hC0);
      wait_fim();
      chk("s1_total_cycles", 64'(cyc - t0), 64'd12);
      chk("s1_nwrites", 64'(wr_addr.size() - bw), 64'd2);
      if (wr_addr.size() - bw == 2) begin
         chk("s1_addr0", 64'(wr_addr[bw]), 64'd0);
         chk("s1_data0", 64'(wr_data[bw]), 64'hB0000000);
         chk("s1_addr1", 64'(wr_addr[bw+1]), 64'd1);
         chk("s1_data1", 64'(wr_data[bw+1]), 64'h50200000);
         chk("s1_we0_latency", 64'(wr_cyc[bw] - t0), 64'd4);
         chk("s1_write_spacing", 64'(wr_cyc[bw+1] - wr_cyc[bw]), 64'd5);
      end
      chk("s1_conc_count", 64'(conc_n - bc), 64'd1);
      chk("s1_conc_time", 64'(conc_cyc - t0), 64'd11);
      chk("s1_conc_erro", 64'(conc_erro), 64'd0);
      chk("s1_erro", 64'(erro), 64'd0);
      chk("s1_hold_addr", 64'(bus.mem_endereco), 64'd1);
      chk("s1_hold_data", 64'(bus.mem_dado), 64'h50200000);

      // Same stream, bad checksum.
      bw = wr_addr.size(); bc = conc_n;
      start(9'd2);
      send_stream(8'hC1);
      wait_fim();
      chk("s2_nwrites", 64'(wr_addr.size() - bw), 64'd2);
      if (wr_addr.size() - bw == 2) begin
         chk("s2_data0", 64'(wr_data[bw]), 64'hB0000000);
         chk("s2_data1", 64'(wr_data[bw+1]), 64'h50200000);
      end
      chk("s2_conc_erro", 64'(conc_erro), 64'd1);
      idle(4);
      chk("s2_erro_sticky", 64'(erro), 64'd1);

      // qtd=0: next inicio clears erro, checksum 00 is correct.
      bw = wr_addr.size(); bc = conc_n;
      start(9'd0);
      chk("q0_erro_cleared", 64'(erro), 64'd0);
      chk("q0_check_pronto", 64'(bus.byte_pronto), 64'd1);
      send_byte(8'h00);
      wait_fim();
      chk("q0_nwrites", 64'(wr_addr.size() - bw), 64'd0);
      chk("q0_conc_count", 64'(conc_n - bc), 64'd1);
      chk("q0_erro", 64'(erro), 64'd0);

      bc = conc_n;
      start(9'd0);
      send_byte(8'h01);
      wait_fim();
      chk("q0b_conc_count", 64'(conc_n - bc), 64'd1);
      chk("q0b_erro", 64'(erro), 64'd1);

      // Backpressure qtd=1 with an ignored mid-session inicio.
      bw = wr_addr.size(); bc = conc_n; bx = xfer_n;
      start(9'd1);
      idle(2);
      send_byte(8'h6C);
      idle(1);
      inicio = 1'b1; qtd = 9'd5;
      tick();
      inicio = 1'b0;
      send_byte(8'h00);
      idle(3);
      send_byte(8'h00);
      send_byte(8'h07);
      chk("bp_escreve_we", 64'(bus.mem_we), 64'd1);
      chk("bp_escreve_pronto", 64'(bus.byte_pronto), 64'd0);
      send_byte(8'h6B);
      wait_fim();
      chk("bp_nwrites", 64'(wr_addr.size() - bw), 64'd1);
      if (wr_addr.size() - bw == 1) begin
         chk("bp_addr0", 64'(wr_addr[bw]), 64'd0);
         chk("bp_data0", 64'(wr_data[bw]), 64'h6C000007);
      end
      chk("bp_transfers", 64'(xfer_n - bx), 64'd5);
      chk("bp_conc_count", 64'(conc_n - bc), 64'd1);
      chk("bp_erro", 64'(erro), 64'd0);

      // Reset mid-session, qtd=3, after 6 bytes.
      bw = wr_addr.size(); bc = conc_n;
      start(9'd3);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
      reset_n = 1'b0;
      #1;
      chk("rst_ocupado", 64'(ocupado), 64'd0);
      chk("rst_outputs", {bus.byte_pronto, bus.mem_we, concluido, erro,
                          bus.mem_endereco, bus.mem_dado}, 64'd0);
      chk("rst_nwrites", 64'(wr_addr.size() - bw), 64'd1);
      if (wr_addr.size() - bw == 1) begin
         chk("rst_addr0", 64'(wr_addr[bw]), 64'd0);
         chk("rst_data0", 64'(wr_data[bw]), 64'h11223344);
      end
      bus.byte_valido = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      chk("rst_no_conc", 64'(conc_n - bc), 64'd0);

      bw = wr_addr.size(); bc = conc_n;
      start(9'd1);
      send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
      send_byte(8'h04);
      wait_fim();
      chk("rs_nwrites", 64'(wr_addr.size() - bw), 64'd1);
      if (wr_addr.size() - bw == 1) begin
         chk("rs_addr0", 64'(wr_addr[bw]), 64'd0);
         chk("rs_data0", 64'(wr_data[bw]), 64'hA1B2C3D4);
      end
      chk("rs_conc_count", 64'(conc_n - bc), 64'd1);
      chk("rs_erro", 64'(erro), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/carregador_instrucao.md
# carregador_instrucao

Program loader that fills the instruction memory of the RISC-32 core from a byte stream before execution. It accepts bytes over a valid/ready handshake and packs them MSB-first into 32-bit words. Each word is written into consecutive instruction-memory addresses starting at 0, and the session ends by checking a trailing XOR checksum byte. It sits between the host/UART byte source and the write port of the instruction memory, which the fetch path reads via a 9-bit address.

## Interface

Parameters:
- none; byte width 8, word width 32 and address width 9 are fixed by the instruction memory.

Ports:
- ck  in  1  system clock, all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- inicio  in  1  start pulse; sampled only in OCIOSO
- qtd  in  9  number of 32-bit words to load (0..511); latched on accepted inicio
- byte_in  in  8  incoming byte
- byte_valido  in  1  byte_in is valid; source holds byte_in stable until accepted
- byte_pronto  out  1  loader can accept a byte this cycle
- mem_we  out  1  instruction-memory write enable, one-cycle pulse per word
- mem_endereco  out  9  write address
- mem_dado  out  32  write data
- ocupado  out  1  session in progress
- concluido  out  1  one-cycle pulse at end of session
- erro  out  1  checksum mismatch; sticky until next accepted inicio

## Operation

- All outputs are decoded from registered state only (Moore); no input-to-output combinational path.
- A byte transfer occurs on a rising edge where byte_valido=1 and byte_pronto=1.
- FSM states: OCIOSO, RECEBE, ESCREVE, CHECK, FIM.
- OCIOSO:
  - byte_pronto=0, ocupado=0.
  - inicio=1 latches qtd, clears the address, word counter, byte counter and XOR accumulator, and clears erro.
  - Next state is CHECK if qtd=0, else RECEBE.
- RECEBE:
  - byte_pronto=1.
  - Each transfer does word <= {word[23:0], byte_in}, acc <= acc ^ byte_in, and increments the 2-bit byte counter.
  - The 4th transfer moves to ESCREVE.
- ESCREVE:
  - Lasts exactly one cycle.
  - mem_we=1, mem_endereco=current address, mem_dado=assembled word, byte_pronto=0.
  - On exit the address and word counter increment.
  - Next state is CHECK if words written = qtd, else RECEBE.
- CHECK:
  - byte_pronto=1.
  - On the transfer, erro <= (byte_in != acc) and the FSM moves to FIM.
- FIM: concluido=1 for one cycle, then OCIOSO.
- ocupado=1 in RECEBE, ESCREVE, CHECK and FIM.
- mem_endereco and mem_dado hold their last values between writes; mem_we is the only write qualifier.
- The checksum covers every data byte of the session; for qtd=0 the expected checksum is 8'h00.

## Timing

- Reset (reset_n=0, asynchronous) forces the FSM to OCIOSO and clears all outputs:
  - byte_pronto, mem_we, ocupado, concluido, erro all 0.
  - mem_endereco=0, mem_dado=0.
- inicio accepted at edge N: byte_pronto=1 from cycle N+1 (RECEBE), or CHECK for qtd=0.
- With byte_valido held high, each word costs exactly 5 cycles: 4 transfers plus 1 ESCREVE.
- mem_we rises the cycle after the 4th byte's transfer edge.
- Minimum session length is 1 + 5·qtd + 1 (CHECK) + 1 (FIM) cycles.
- Boundary conditions:
  - inicio outside OCIOSO is ignored; qtd changes outside OCIOSO are ignored.
  - byte_valido while byte_pronto=0 (OCIOSO, ESCREVE, FIM) consumes nothing; the source must hold.
  - The maximum address written is 510 (qtd=511); the address never wraps.
  - Deasserting reset_n mid-session aborts immediately: no further writes, words already written stay in memory, erro=0, and no concluido pulse is produced.
  - erro remains valid after FIM until the next accepted inicio or reset.

## Test plan

- Reset: hold reset_n=0 with random inputs -> all outputs 0; release, byte_valido=1 -> byte_pronto stays 0, no mem_we.
- qtd=2, bytes B0 00 00 00 50 20 00 00, checksum C0, byte_valido continuous:
  - Write addr 0 = 32'hB0000000, then addr 1 = 32'h50200000, 5 cycles apart.
  - concluido pulses once with erro=0; total 13 cycles from inicio.
- Same stream with checksum C1 -> same two writes; erro=1 after CHECK and held until the next inicio, which clears it.
- Backpressure, qtd=1, bytes 6C 00 00 07, checksum 6B:
  - byte_valido toggles 1/0 irregularly -> exactly one write, addr 0 = 32'h6C000007.
  - No transfer during ESCREVE; an inicio pulse mid-session is ignored.
- qtd=0, inicio, then checksum byte 00 -> no mem_we, concluido pulse, erro=0; a second run with byte 01 -> erro=1.
- Reset mid-session, qtd=3:
  - Drop reset_n after 6 bytes -> exactly one write was made (addr 0), ocupado=0 immediately.
  - Restart with qtd=1 -> the write goes to addr 0.
